// File: rtl/button_event_classifier_if.sv
// button_event_classifier_if: debounced button level in, gesture events and status flags out
interface button_event_classifier_if;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic double_press;
  logic long_held;
  logic busy;
  modport master (
    output btn_level,
    input  short_press, long_press, double_press, long_held, busy
  );
  modport slave (
    input  btn_level,
    output short_press, long_press, double_press, long_held, busy
  );
endinterface

// File: rtl/button_event_classifier.sv
// button_event_classifier: turns a debounced button level into short/long/double press pulses
module button_event_classifier #(
  parameter int long_cycles = 2000000,
  parameter int gap_cycles  = 500000,
  parameter int cnt_width   = 24
) (
  input logic                       clk,
  input logic                       as_reset,
  button_event_classifier_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, PRESS1, LONG, GAP, PRESS2} state_t;
  localparam logic [cnt_width-1:0] long_last = cnt_width'(long_cycles - 1);
  localparam logic [cnt_width-1:0] gap_last  = cnt_width'(gap_cycles - 1);
  state_t               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 prev_q;
  logic                 short_q, short_d, long_q, long_d, dbl_q, dbl_d;
  logic                 rise, fall;
  assign rise = bus.btn_level & ~prev_q;
  assign fall = ~bus.btn_level & prev_q;
  // next state, shared interval counter and event pulses; a fall beats the long threshold and a rise beats the gap timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    case (state_q)
      IDLE:
        if (rise) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      PRESS1:
        if (fall) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == long_last) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      LONG:
        if (fall) state_d = IDLE;
      GAP:
        if (rise) begin
          state_d = PRESS2;
          dbl_d   = 1'b1;
        end else if (cnt_q == gap_last) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      PRESS2:
        if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, counter, edge history and registered pulses; prev clears on reset so a held button reads as a new press
  always_ff @(posedge clk or posedge as_reset) begin
    if (as_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= bus.btn_level;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
    end
  end
  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = dbl_q;
  assign bus.long_held    = state_q == LONG;
  assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_button_event_classifier.sv
// tb_button_event_classifier: scoreboard bench for gesture classification with long_cycles=8, gap_cycles=6
module tb_button_event_classifier;
  localparam logic [2:0] EV_SHORT = 3'b001, EV_LONG = 3'b010, EV_DBL = 3'b100;
  typedef struct {logic [2:0] kind; int at;} exp_t;
  logic clk = 1'b0;
  logic as_reset;
  int   n = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  button_event_classifier_if bus ();
  button_event_classifier #(.long_cycles(8), .gap_cycles(6), .cnt_width(24)) dut (
    .clk      (clk),
    .as_reset (as_reset),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask
  function automatic logic [4:0] outs();
    return {bus.short_press, bus.long_press, bus.double_press, bus.long_held, bus.busy};
  endfunction
  task automatic expect_ev(input logic [2:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask
  task automatic step(input logic lvl);
    logic [2:0] ev;
    exp_t e;
    bus.btn_level = lvl;
    @(posedge clk);
    #1;
    n++;
    while (sb.size() != 0 && sb[0].at < n) begin
      e = sb.pop_front();
      chk("missed_event", 32'(3'b000), 32'(e.kind));
    end
    ev = {bus.double_press, bus.long_press, bus.short_press};
    if (ev != 3'b000) begin
      if (sb.size() == 0) chk("unexpected_event", 32'(ev), 32'(3'b000));
      else begin
        e = sb.pop_front();
        chk("event_kind", 32'(ev), 32'(e.kind));
        chk("event_edge", 32'(n), 32'(e.at));
      end
      if (bus.short_press) chk("busy_at_short", 32'(bus.busy), 32'(1'b0));
    end
  endtask
  task automatic drive(input logic lvl, input int cnt);
    for (int i = 0; i < cnt; i++) step(lvl);
  endtask
  initial begin
    int s;
    as_reset = 1'b1;
    bus.btn_level = 1'b0;
    drive(1'b0, 2);
    chk("reset_outputs", 32'(outs()), 32'(5'b0));
    as_reset = 1'b0;
    drive(1'b0, 3);
    // short press: high 3, release, pulse 6 edges after release edge
    s = n + 1;
    expect_ev(EV_SHORT, s + 3 + 6);
    drive(1'b1, 3);
    chk("short_busy", 32'(bus.busy), 32'(1'b1));
    drive(1'b0, 12);
    chk("short_idle", 32'(outs()), 32'(5'b0));
    // long press: held 20, pulse 8 edges after rise
    s = n + 1;
    expect_ev(EV_LONG, s + 8);
    drive(1'b1, 8);
    chk("held_before", 32'(bus.long_held), 32'(1'b0));
    drive(1'b1, 1);
    chk("held_at_pulse", 32'(bus.long_held), 32'(1'b1));
    drive(1'b1, 11);
    chk("held_during", 32'(bus.long_held), 32'(1'b1));
    drive(1'b0, 1);
    chk("held_after_rel", 32'(bus.long_held), 32'(1'b0));
    chk("long_busy_rel", 32'(bus.busy), 32'(1'b0));
    drive(1'b0, 10);
    // double press: high 2, low 3, high 2, low
    s = n + 1;
    expect_ev(EV_DBL, s + 5);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 2);
    chk("dbl_busy", 32'(bus.busy), 32'(1'b1));
    drive(1'b0, 1);
    chk("dbl_busy_rel", 32'(bus.busy), 32'(1'b0));
    drive(1'b0, 10);
    // release exactly at cnt==7 in PRESS1: fall wins, short follows
    s = n + 1;
    expect_ev(EV_SHORT, s + 8 + 6);
    drive(1'b1, 8);
    drive(1'b0, 12);
    // second rise exactly at cnt==5 in GAP: rise wins, double not short
    s = n + 1;
    expect_ev(EV_DBL, s + 8);
    drive(1'b1, 2);
    drive(1'b0, 6);
    drive(1'b1, 2);
    drive(1'b0, 10);
    // reset while in LONG clears everything asynchronously
    s = n + 1;
    expect_ev(EV_LONG, s + 8);
    drive(1'b1, 10);
    chk("held_pre_rst", 32'(bus.long_held), 32'(1'b1));
    #2 as_reset = 1'b1;
    #1 chk("async_rst_outs", 32'(outs()), 32'(5'b0));
    drive(1'b0, 2);
    as_reset = 1'b0;
    drive(1'b0, 3);
    chk("post_rst_idle", 32'(outs()), 32'(5'b0));
    s = n + 1;
    expect_ev(EV_SHORT, s + 2 + 6);
    drive(1'b1, 2);
    drive(1'b0, 12);
    // reset released with button high counts as a new press
    as_reset = 1'b1;
    drive(1'b1, 2);
    as_reset = 1'b0;
    s = n + 1;
    expect_ev(EV_SHORT, s + 2 + 6);
    drive(1'b1, 2);
    drive(1'b0, 12);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Sits directly downstream of the input debouncer and consumes its clean, clock-synchronous level output.
- Turns button activity into single-cycle event pulses: short press, long press and double press.
- Also drives a level flag while a long press is held and a busy flag while a gesture is being classified.
- Feeds control logic that acts on discrete user gestures rather than raw levels.

Parameters:
- long_cycles, 2000000, press duration (clk cycles in PRESS1) that qualifies as a long press; must be 2..2^cnt_width.
- gap_cycles, 500000, maximum release-to-second-press interval (clk cycles in GAP) for a double press; must be 2..2^cnt_width.
- cnt_width, 24, width of the shared interval counter.

Ports:
- clk  input  1  system clock.
- as_reset  input  1  asynchronous, active-high reset.
- btn_level  input  1  debounced button level, already synchronous to clk; 1 = pressed.
- short_press  output  1  one-cycle pulse: a single press released before long_cycles, with no second press within gap_cycles.
- long_press  output  1  one-cycle pulse when a press reaches long_cycles.
- double_press  output  1  one-cycle pulse on the second press of a double press.
- long_held  output  1  high from the long_press pulse cycle until the button is released.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: as_reset asserted forces, immediately and asynchronously:
  - state = IDLE, cnt = 0, prev = 0;
  - all outputs = 0.
- Reset mid-gesture aborts the gesture and emits no event.
- Edge detection:
  - prev <= btn_level every cycle.
  - rise = btn_level & ~prev; fall = ~btn_level & prev.
  - prev resets to 0, so a button already high when reset releases is treated as a new press.
- All outputs are registered and reflect decisions taken at the preceding clock edge.
- Event pulses last exactly one cycle.
- States and transitions:
  - IDLE: on rise, go to PRESS1 with cnt <= 0.
  - PRESS1:
    - fall: go to GAP with cnt <= 0.
    - else, if cnt == long_cycles-1: go to LONG, pulse long_press, set long_held = 1.
    - otherwise: cnt <= cnt+1.
    - fall takes priority over reaching the long threshold on the same edge; the result is the short/double path.
  - LONG: long_held stays 1. On fall, go to IDLE and clear long_held. No short or double event is produced.
  - GAP:
    - rise: go to PRESS2 and pulse double_press.
    - else, if cnt == gap_cycles-1: go to IDLE and pulse short_press.
    - otherwise: cnt <= cnt+1.
    - rise takes priority over gap timeout on the same edge.
  - PRESS2: wait for fall, then go to IDLE. No long detection; no further events. A third press is seen only after returning to IDLE.
- Latencies (measured from the edge at which btn_level is first sampled):
  - long_press is high in the cycle after the edge at which PRESS1 has been occupied for long_cycles edges.
  - A short_press pulse appears gap_cycles edges after the release edge.
  - double_press appears one cycle after the second rise is sampled.
- Counter: unsigned, cnt_width bits. It never wraps, because its range is bounded by the parameter limits.
- At most one event pulse is asserted in any cycle.

Test Plan:
- Sim parameters for all cases: long_cycles=8, gap_cycles=6.
- Short press: btn_level high 3 cycles then low -> short_press pulses exactly once, 6 cycles after release. long_press and double_press stay 0. busy returns to 0 with the pulse.
- Long press: btn_level held high 20 cycles -> long_press pulses once, 8 cycles after the rise is sampled. long_held is 1 from the pulse until 1 cycle after release. No short_press follows.
- Double press: high 2, low 3, high 2, low -> double_press pulses 1 cycle after the second rise. No short_press. busy goes low after the second release.
- Boundary cases:
  - Release exactly when cnt==7 in PRESS1 -> no long_press; short_press follows after the gap.
  - Second rise exactly when cnt==5 in GAP -> double_press, not short_press.
- Reset mid-operation: assert as_reset while in LONG (long_held=1) -> all outputs 0 immediately. A press after deassert is classified normally.
- Reset release with btn_level=1 -> treated as a press; low after 2 cycles then idle -> short_press.
